// File: rtl/i2c_s_if.sv
// Bus-side and register-side signals of the i2c_s target endpoint.
// Read handshake: s_i2c_dr is the ready/request, s_i2c_dv the valid; a byte moves on
// the clk edge where both are high, and s_i2c_dr then drops by itself.
interface i2c_s_if;
    logic       scl;
    logic       sda_i;
    logic       sda_o;
    logic       sda_oe;
    logic [7:0] m_i2c_ra;
    logic [7:0] m_i2c_d;
    logic       m_i2c_dv;
    logic       s_i2c_dr;
    logic [7:0] s_i2c_d;
    logic       s_i2c_dv;
    logic       busy;
    logic       nack;
    logic [3:0] dbg_state;

    modport slave (
        input  scl, sda_i, s_i2c_d, s_i2c_dv,
        output sda_o, sda_oe, m_i2c_ra, m_i2c_d, m_i2c_dv, s_i2c_dr, busy, nack, dbg_state
    );

    modport master (
        output scl, sda_i, s_i2c_d, s_i2c_dv,
        input  sda_o, sda_oe, m_i2c_ra, m_i2c_d, m_i2c_dv, s_i2c_dr, busy, nack, dbg_state
    );
endinterface

// File: rtl/i2c_s.sv
// I2C target: START/STOP detection, 7-bit address match, optional register-address
// byte, byte writes to and reads from a local register port. SCL is never stretched.
module i2c_s #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h41,
    parameter bit         REG_ADDR_EN = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    rst,
    i2c_s_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_q, sda_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] rx, rx_n;
    logic [7:0] tx, tx_n;
    logic       tx_vld, tx_vld_n;
    logic [7:0] tx_sh, tx_sh_n;
    logic       rw, rw_n;
    logic       wr_seen, wr_seen_n;
    logic       sda_oe_r, sda_oe_n;
    logic       sda_o_r, sda_o_n;
    logic [7:0] ra, ra_n;
    logic [7:0] wd, wd_n;
    logic       dv, dv_n;
    logic       dr, dr_n;
    logic       busy_r, busy_n;
    logic       nack_r, nack_n;
    logic [7:0] rx_byte, tx_byte;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & scl_q & sda_q & ~sda_s;
    assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

    assign bus.sda_oe    = sda_oe_r;
    assign bus.sda_o     = sda_o_r;
    assign bus.m_i2c_ra  = ra;
    assign bus.m_i2c_d   = wd;
    assign bus.m_i2c_dv  = dv;
    assign bus.s_i2c_dr  = dr;
    assign bus.busy      = busy_r;
    assign bus.nack      = nack_r;
    assign bus.dbg_state = state;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        rx_n      = rx;
        tx_n      = tx;
        tx_vld_n  = tx_vld;
        tx_sh_n   = tx_sh;
        rw_n      = rw;
        wr_seen_n = wr_seen;
        sda_oe_n  = sda_oe_r;
        sda_o_n   = sda_o_r;
        ra_n      = ra;
        wd_n      = wd;
        dv_n      = 1'b0;
        dr_n      = dr;
        busy_n    = busy_r;
        nack_n    = 1'b0;
        rx_byte   = {rx[6:0], sda_s};
        // A byte arriving in the same cycle as the SCL fall is the one that goes out.
        tx_byte   = (dr && bus.s_i2c_dv) ? bus.s_i2c_d : (tx_vld ? tx : 8'hFF);

        if (dr && bus.s_i2c_dv) begin
            tx_n     = bus.s_i2c_d;
            tx_vld_n = 1'b1;
            dr_n     = 1'b0;
        end

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
            sda_o_n   = 1'b1;
            dr_n      = 1'b0;
            tx_vld_n  = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd0;
            sda_oe_n  = 1'b0;
            sda_o_n   = 1'b1;
            busy_n    = 1'b0;
            dr_n      = 1'b0;
            tx_vld_n  = 1'b0;
            wr_seen_n = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, REG, WR: begin
                    rx_n = rx_byte;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = 3'd0;
                        if (state == ADDR) begin
                            if (rx_byte[7:1] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = rx_byte[0];
                            end else begin
                                state_n = IGNORE;
                            end
                        end else if (state == REG) begin
                            ra_n    = rx_byte;
                            state_n = REG_ACK;
                        end else begin
                            wd_n    = rx_byte;
                            dv_n    = 1'b1;
                            state_n = WR_ACK;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                ADDR_ACK, REG_ACK, WR_ACK: begin
                    bit_cnt_n = 3'd1;
                    if (state == ADDR_ACK && rw && bit_cnt == 3'd0) dr_n = 1'b1;
                end
                RD: begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = 3'd0;
                        state_n   = RD_ACK;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (bit_cnt == 3'd0) begin
                        ra_n = ra + 8'd1;
                        if (!sda_s) begin
                            bit_cnt_n = 3'd1;
                            dr_n      = 1'b1;
                        end else begin
                            nack_n  = 1'b1;
                            state_n = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ADDR_ACK, REG_ACK, WR_ACK: begin
                    if (bit_cnt == 3'd0) begin
                        sda_oe_n = 1'b1;
                        sda_o_n  = 1'b0;
                    end else begin
                        // ACK clock done: release, then pick the next byte phase.
                        sda_oe_n  = 1'b0;
                        sda_o_n   = 1'b1;
                        bit_cnt_n = 3'd0;
                        if (state == ADDR_ACK && rw) begin
                            state_n  = RD;
                            sda_oe_n = 1'b1;
                            sda_o_n  = tx_byte[7];
                            tx_sh_n  = {tx_byte[6:0], 1'b1};
                            dr_n     = 1'b0;
                            tx_vld_n = 1'b0;
                        end else if (state == ADDR_ACK) begin
                            wr_seen_n = 1'b1;
                            state_n   = (REG_ADDR_EN && !wr_seen) ? REG : WR;
                        end else if (state == REG_ACK) begin
                            state_n = WR;
                        end else begin
                            state_n = WR;
                            ra_n    = ra + 8'd1;
                        end
                    end
                end
                RD: begin
                    sda_oe_n = 1'b1;
                    sda_o_n  = tx_sh[7];
                    tx_sh_n  = {tx_sh[6:0], 1'b1};
                end
                RD_ACK: begin
                    if (bit_cnt == 3'd0) begin
                        sda_oe_n = 1'b0;
                        sda_o_n  = 1'b1;
                    end else begin
                        state_n   = RD;
                        bit_cnt_n = 3'd0;
                        sda_oe_n  = 1'b1;
                        sda_o_n   = tx_byte[7];
                        tx_sh_n   = {tx_byte[6:0], 1'b1};
                        dr_n      = 1'b0;
                        tx_vld_n  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Synchronizers reset high so an idle bus produces no edges after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx       <= 8'd0;
            tx       <= 8'd0;
            tx_vld   <= 1'b0;
            tx_sh    <= 8'hFF;
            rw       <= 1'b0;
            wr_seen  <= 1'b0;
            sda_oe_r <= 1'b0;
            sda_o_r  <= 1'b1;
            ra       <= 8'd0;
            wd       <= 8'd0;
            dv       <= 1'b0;
            dr       <= 1'b0;
            busy_r   <= 1'b0;
            nack_r   <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            rx       <= rx_n;
            tx       <= tx_n;
            tx_vld   <= tx_vld_n;
            tx_sh    <= tx_sh_n;
            rw       <= rw_n;
            wr_seen  <= wr_seen_n;
            sda_oe_r <= sda_oe_n;
            sda_o_r  <= sda_o_n;
            ra       <= ra_n;
            wd       <= wd_n;
            dv       <= dv_n;
            dr       <= dr_n;
            busy_r   <= busy_n;
            nack_r   <= nack_n;
        end
    end

endmodule

// File: tb/tb_i2c_s.sv
// Directed bench for i2c_s: bus-master tasks, a register-side responder and a
// write-strobe scoreboard, driven from a table of write transactions plus read sequences.
module tb_i2c_s;
    localparam int Q = 20;

    logic clk = 1'b0;
    logic rst;
    logic m_scl, m_sda;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    i2c_s_if bus();
    assign bus.scl   = m_scl;
    assign bus.sda_i = m_sda & ~(bus.sda_oe & ~bus.sda_o);

    i2c_s #(.SLAVE_ADDR(7'h41), .REG_ADDR_EN(1'b1), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] exp_q[$];
    logic [7:0]  dr_ra_q[$];
    logic [7:0]  rd_q[$];
    int          nack_cnt;
    logic        oe_seen;
    bit          resp_en;
    bit          dr_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(4);
    endtask

    task automatic bus_stop;
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        s = bus.sda_i;
        m_scl = 1'b0; wait_clk(4);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            b[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    // Scoreboard for write strobes and nack pulses.
    always @(negedge clk) begin
        if (!rst && bus.m_i2c_dv) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_dv: got ra=%0h d=%0h expected no strobe", bus.m_i2c_ra, bus.m_i2c_d);
            end else begin
                check("dv_ra_d", 32'({bus.m_i2c_ra, bus.m_i2c_d}), 32'(exp_q.pop_front()));
            end
        end
        if (!rst && bus.nack) nack_cnt++;
        if (bus.sda_oe) oe_seen = 1'b1;
    end

    // Register-side user: logs each read request and answers from rd_q when enabled.
    initial begin
        bus.s_i2c_dv = 1'b0;
        bus.s_i2c_d  = 8'h00;
        dr_seen      = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.s_i2c_dr && !dr_seen) begin
                dr_seen = 1'b1;
                dr_ra_q.push_back(bus.m_i2c_ra);
                if (resp_en && rd_q.size() > 0) begin
                    wait_clk(3);
                    bus.s_i2c_d  = rd_q.pop_front();
                    bus.s_i2c_dv = 1'b1;
                    @(negedge clk);
                    bus.s_i2c_dv = 1'b0;
                end
            end
            if (!bus.s_i2c_dr) dr_seen = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] reg_b;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
    } wr_vec_t;

    wr_vec_t vecs[5];

    initial begin
        logic       ack;
        logic [7:0] b;
        logic [7:0] ra1;
        int         cyc;

        vecs[0] = '{8'h82, 8'h81, 8'h4D, 8'h33, 1'b1};
        vecs[1] = '{8'h84, 8'h10, 8'h55, 8'hAA, 1'b0};
        vecs[2] = '{8'h82, 8'hFF, 8'h11, 8'h22, 1'b1};
        vecs[3] = '{8'h02, 8'h20, 8'h01, 8'h02, 1'b0};
        vecs[4] = '{8'h82, 8'h00, 8'hA5, 8'h5A, 1'b1};

        resp_en  = 1'b0;
        nack_cnt = 0;
        oe_seen  = 1'b0;
        m_scl    = 1'b1;
        m_sda    = 1'b1;
        rst      = 1'b1;
        wait_clk(5);
        check("rst_sda_oe", 32'(bus.sda_oe), 32'h0);
        check("rst_sda_o", 32'(bus.sda_o), 32'h1);
        check("rst_ra", 32'(bus.m_i2c_ra), 32'h0);
        check("rst_d", 32'(bus.m_i2c_d), 32'h0);
        check("rst_dv", 32'(bus.m_i2c_dv), 32'h0);
        check("rst_dr", 32'(bus.s_i2c_dr), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_nack", 32'(bus.nack), 32'h0);
        check("rst_state", 32'(bus.dbg_state), 32'h0);
        rst = 1'b0;
        wait_clk(5);

        for (int i = 0; i < 5; i++) begin
            oe_seen = 1'b0;
            if (vecs[i].exp_ack) begin
                ra1 = vecs[i].reg_b + 8'd1;
                exp_q.push_back({vecs[i].reg_b, vecs[i].d0});
                exp_q.push_back({ra1, vecs[i].d1});
            end
            bus_start;
            write_byte(vecs[i].addr_b, ack);
            check("addr_ack", 32'(ack), 32'(vecs[i].exp_ack));
            check("busy_addr", 32'(bus.busy), 32'(vecs[i].exp_ack));
            write_byte(vecs[i].reg_b, ack);
            check("reg_ack", 32'(ack), 32'(vecs[i].exp_ack));
            write_byte(vecs[i].d0, ack);
            check("d0_ack", 32'(ack), 32'(vecs[i].exp_ack));
            write_byte(vecs[i].d1, ack);
            check("d1_ack", 32'(ack), 32'(vecs[i].exp_ack));
            bus_stop;
            wait_clk(8);
            check("busy_stop", 32'(bus.busy), 32'h0);
            check("dv_drained", 32'(exp_q.size()), 32'h0);
            if (!vecs[i].exp_ack) check("no_drive", 32'(oe_seen), 32'h0);
            exp_q.delete();
        end

        // Register write, repeated START, two-byte read ending in NACK.
        rd_q = '{8'h53, 8'h33};
        dr_ra_q.delete();
        resp_en  = 1'b1;
        nack_cnt = 0;
        bus_start;
        write_byte(8'h82, ack);
        check("rd_waddr_ack", 32'(ack), 32'h1);
        write_byte(8'h81, ack);
        check("rd_reg_ack", 32'(ack), 32'h1);
        bus_start;
        write_byte(8'h83, ack);
        check("rd_raddr_ack", 32'(ack), 32'h1);
        read_byte(b, 1'b1);
        check("rd_byte0", 32'(b), 32'h53);
        read_byte(b, 1'b0);
        check("rd_byte1", 32'(b), 32'h33);
        bus_stop;
        wait_clk(8);
        check("rd_dr_count", 32'(dr_ra_q.size()), 32'h2);
        check("rd_dr_ra0", 32'((dr_ra_q.size() > 0) ? dr_ra_q[0] : 8'h00), 32'h81);
        check("rd_dr_ra1", 32'((dr_ra_q.size() > 1) ? dr_ra_q[1] : 8'h00), 32'h82);
        check("rd_nack_cnt", 32'(nack_cnt), 32'h1);
        check("rd_ra_end", 32'(bus.m_i2c_ra), 32'h83);
        check("rd_busy_end", 32'(bus.busy), 32'h0);

        // Read with no user response: the bus sees FF and the slave still returns to IDLE.
        resp_en  = 1'b0;
        nack_cnt = 0;
        dr_ra_q.delete();
        bus_start;
        write_byte(8'h83, ack);
        check("nr_addr_ack", 32'(ack), 32'h1);
        read_byte(b, 1'b0);
        check("nr_byte", 32'(b), 32'hFF);
        check("nr_dr_dropped", 32'(bus.s_i2c_dr), 32'h0);
        bus_stop;
        wait_clk(8);
        check("nr_dr_seen", 32'(dr_ra_q.size()), 32'h1);
        check("nr_nack_cnt", 32'(nack_cnt), 32'h1);
        check("nr_state_idle", 32'(bus.dbg_state), 32'h0);
        check("nr_sda_oe", 32'(bus.sda_oe), 32'h0);
        check("nr_ra", 32'(bus.m_i2c_ra), 32'h84);

        // Reset while the slave is driving read data, then a clean write address.
        resp_en = 1'b1;
        rd_q    = '{8'h00};
        bus_start;
        write_byte(8'h83, ack);
        check("rr_addr_ack", 32'(ack), 32'h1);
        cyc = 0;
        while (!bus.sda_oe && cyc < 40) begin
            wait_clk(1);
            cyc++;
        end
        check("rr_driving", 32'(bus.sda_oe), 32'h1);
        check("rr_bit7", 32'(bus.sda_o), 32'h0);
        rst = 1'b1;
        #1;
        check("rr_sda_oe", 32'(bus.sda_oe), 32'h0);
        check("rr_sda_o", 32'(bus.sda_o), 32'h1);
        check("rr_ra", 32'(bus.m_i2c_ra), 32'h0);
        check("rr_d", 32'(bus.m_i2c_d), 32'h0);
        check("rr_dv", 32'(bus.m_i2c_dv), 32'h0);
        check("rr_dr", 32'(bus.s_i2c_dr), 32'h0);
        check("rr_busy", 32'(bus.busy), 32'h0);
        check("rr_nack", 32'(bus.nack), 32'h0);
        check("rr_state", 32'(bus.dbg_state), 32'h0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(5);
        bus_start;
        write_byte(8'h82, ack);
        check("rr_after_ack", 32'(ack), 32'h1);
        check("rr_after_busy", 32'(bus.busy), 32'h1);
        bus_stop;
        wait_clk(8);
        check("rr_after_stop", 32'(bus.busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
